// File: rtl/uart_tx_sched_if.sv
// Bundle of the requester handshakes and the shared baud-generator /
// transmitter connections for the UART transmit scheduler.
interface uart_tx_sched_if;
   // Requester 0
   logic       req0_valid;
   logic [7:0] req0_data;
   logic [1:0] req0_baud;
   logic       req0_ready;

   // Requester 1
   logic       req1_valid;
   logic [7:0] req1_data;
   logic [1:0] req1_baud;
   logic       req1_ready;

   // Shared baud generator and transmitter
   logic [1:0] baud_rate;
   logic       baud_rst;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;

   // Status
   logic       busy;
   logic       grant;
   logic       timeout_err;

   // Scheduler side
   modport slave (
      input  req0_valid, req0_data, req0_baud,
      input  req1_valid, req1_data, req1_baud,
      input  tx_done,
      output req0_ready, req1_ready,
      output baud_rate, baud_rst, tx_start, tx_data,
      output busy, grant, timeout_err
   );

   // Requester / transmitter side
   modport master (
      output req0_valid, req0_data, req0_baud,
      output req1_valid, req1_data, req1_baud,
      output tx_done,
      input  req0_ready, req1_ready,
      input  baud_rate, baud_rst, tx_start, tx_data,
      input  busy, grant, timeout_err
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester scheduler for one shared UART transmitter and baud generator.
// Arbitrates round-robin on ties, reprograms the baud generator only when the
// winner's baud select differs from the current one, issues a single start
// pulse and waits for the frame to finish (with a timeout guard).
module uart_tx_sched #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 600000
) (
   input  logic           clock,
   input  logic           rst_n,
   uart_tx_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CFG   = 2'd1,
      START = 2'd2,
      WAIT  = 2'd3
   } state_t;

   // Terminal values of the settle and wait counters (both count from zero).
   localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
   localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

   // Baud select driven out of reset: 9600.
   localparam logic [1:0]  BAUD_DEFAULT = 2'b10;

   state_t      state_reg,       state_next;
   logic [7:0]  data_reg,        data_next;
   logic [1:0]  baud_reg,        baud_next;
   logic        baud_rst_reg,    baud_rst_next;
   logic        tx_start_reg,    tx_start_next;
   logic        grant_reg,       grant_next;
   logic        busy_reg,        busy_next;
   logic        timeout_err_reg, timeout_err_next;
   // Index of the requester served last; on a tie the other one wins.
   logic        pointer_reg,     pointer_next;
   logic [7:0]  settle_cnt_reg,  settle_cnt_next;
   logic [19:0] wait_cnt_reg,    wait_cnt_next;

   logic        pick0;
   logic        pick1;
   logic [7:0]  sel_data;
   logic [1:0]  sel_baud;

   // Arbitration: only in IDLE, at most one winner, tie broken by the pointer.
   always_comb begin
      pick0 = 1'b0;
      pick1 = 1'b0;
      if (state_reg == IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (pointer_reg) begin
               pick0 = 1'b1;
            end else begin
               pick1 = 1'b1;
            end
         end else if (bus.req0_valid) begin
            pick0 = 1'b1;
         end else if (bus.req1_valid) begin
            pick1 = 1'b1;
         end
      end
   end

   assign sel_data = pick1 ? bus.req1_data : bus.req0_data;
   assign sel_baud = pick1 ? bus.req1_baud : bus.req0_baud;

   assign bus.req0_ready = pick0;
   assign bus.req1_ready = pick1;

   // Next-state and next-output logic; every registered output is computed here.
   always_comb begin
      state_next       = state_reg;
      data_next        = data_reg;
      baud_next        = baud_reg;
      baud_rst_next    = 1'b0;
      tx_start_next    = 1'b0;
      grant_next       = grant_reg;
      pointer_next     = pointer_reg;
      timeout_err_next = 1'b0;
      settle_cnt_next  = settle_cnt_reg;
      wait_cnt_next    = wait_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (pick0 || pick1) begin
               data_next  = sel_data;
               grant_next = pick1;
               if (sel_baud != baud_reg) begin
                  // New rate takes effect on CFG entry, generator held in reset.
                  state_next      = CFG;
                  baud_next       = sel_baud;
                  baud_rst_next   = 1'b1;
                  settle_cnt_next = 8'd0;
               end else begin
                  state_next    = START;
                  tx_start_next = 1'b1;
               end
            end
         end

         CFG: begin
            if (settle_cnt_reg == SETTLE_LAST) begin
               state_next    = START;
               tx_start_next = 1'b1;
            end else begin
               baud_rst_next   = 1'b1;
               settle_cnt_next = settle_cnt_reg + 8'd1;
            end
         end

         START: begin
            state_next    = WAIT;
            wait_cnt_next = 20'd0;
         end

         WAIT: begin
            // A done on the terminal count still wins over the timeout.
            if (bus.tx_done) begin
               state_next   = IDLE;
               pointer_next = grant_reg;
            end else if (wait_cnt_reg == TIMEOUT_LAST) begin
               state_next       = IDLE;
               pointer_next     = grant_reg;
               timeout_err_next = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 20'd1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         data_reg        <= 8'd0;
         baud_reg        <= BAUD_DEFAULT;
         baud_rst_reg    <= 1'b1;
         tx_start_reg    <= 1'b0;
         grant_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
         pointer_reg     <= 1'b1;
         settle_cnt_reg  <= 8'd0;
         wait_cnt_reg    <= 20'd0;
      end else begin
         state_reg       <= state_next;
         data_reg        <= data_next;
         baud_reg        <= baud_next;
         baud_rst_reg    <= baud_rst_next;
         tx_start_reg    <= tx_start_next;
         grant_reg       <= grant_next;
         busy_reg        <= busy_next;
         timeout_err_reg <= timeout_err_next;
         pointer_reg     <= pointer_next;
         settle_cnt_reg  <= settle_cnt_next;
         wait_cnt_reg    <= wait_cnt_next;
      end
   end

   assign bus.baud_rate   = baud_reg;
   assign bus.baud_rst    = baud_rst_reg;
   assign bus.tx_start    = tx_start_reg;
   assign bus.tx_data     = data_reg;
   assign bus.busy        = busy_reg;
   assign bus.grant       = grant_reg;
   assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized
// transactions checked against a transaction-level model (last grant, current
// baud select, expected start latency).
module tb_uart_tx_sched;
   localparam int SETTLE = 4;
   localparam int TMO    = 50;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Transaction-level model state
   logic       m_last;
   logic [1:0] m_baud;

   uart_tx_sched_if bus ();

   uart_tx_sched #(
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

   // Winner from the arbitration rule: single valid wins, tie -> not-last.
   function automatic int model_winner(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return last ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic idle_inputs();
      bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_baud = 2'b00;
      bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_baud = 2'b00;
      bus.tx_done    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clock);
      rst_n  = 1'b1;
      m_last = 1'b1;
      m_baud = 2'b10;
   endtask

   // Present one request, then follow it to tx_start and report what was seen.
   task automatic run_accept(input logic v0, input logic v1,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [1:0] b0, input logic [1:0] b1,
                             output logic r0, output logic r1, output int lat,
                             output int rst_cnt, output logic [7:0] data_s,
                             output logic gnt_s, output logic [1:0] baud_s);
      @(negedge clock);
      bus.req0_valid = v0; bus.req0_data = d0; bus.req0_baud = b0;
      bus.req1_valid = v1; bus.req1_data = d1; bus.req1_baud = b1;
      #1;
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      lat = -1; rst_cnt = 0; data_s = 8'h00; gnt_s = 1'b0; baud_s = 2'b00;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clock);
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
         if (bus.baud_rst) rst_cnt++;
         if (bus.tx_start) begin
            lat = n; data_s = bus.tx_data; gnt_s = bus.grant; baud_s = bus.baud_rate;
            break;
         end
      end
   endtask

   // From the START cycle: wait, pulse tx_done, land in the first IDLE cycle.
   task automatic finish_txn(input int delay);
      repeat (delay) @(negedge clock);
      bus.tx_done = 1'b1;
      @(negedge clock);
      bus.tx_done = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clock);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
      checks++; if (bus.baud_rate !== 2'b10) begin errors++; $display("FAIL rst_baud got %b want 10", bus.baud_rate); end
      checks++; if (bus.baud_rst !== 1'b1) begin errors++; $display("FAIL rst_baud_rst got %b want 1", bus.baud_rst); end
      checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", bus.tx_start); end
      checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", bus.tx_data); end
      checks++; if (bus.grant !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_grant_err got %b%b want 00", bus.grant, bus.timeout_err); end
      rst_n = 1'b1;
      @(negedge clock);
      checks++; if (bus.baud_rst !== 1'b0) begin errors++; $display("FAIL rst_release_baud_rst got %b want 0", bus.baud_rst); end
      $display("txn reset: baud_rate=%b baud_rst=%b busy=%b", bus.baud_rate, bus.baud_rst, bus.busy);
      m_last = 1'b1;
      m_baud = 2'b10;
   endtask

   task automatic test_directed();
      logic r0, r1, g; int lat, rc; logic [7:0] d; logic [1:0] b;
      run_accept(1'b1, 1'b0, 8'hA5, 8'h00, 2'b10, 2'b00, r0, r1, lat, rc, d, g, b);
      $display("txn directed0: ready=%b%b lat=%0d rst=%0d data=%h grant=%b", r0, r1, lat, rc, d, g);
      checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL dir0_ready got %b%b want 10", r0, r1); end
      checks++; if (lat != 1 || rc != 0) begin errors++; $display("FAIL dir0_latency got lat=%0d rst=%0d want lat=1 rst=0", lat, rc); end
      checks++; if (d !== 8'hA5 || g !== 1'b0) begin errors++; $display("FAIL dir0_data got %h/%b want a5/0", d, g); end
      finish_txn(2);
      checks++; if (bus.busy !== 1'b0 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL dir0_done got busy=%b data=%h want busy=0 data=a5", bus.busy, bus.tx_data); end
      m_last = 1'b0;
      run_accept(1'b0, 1'b1, 8'h00, 8'h3C, 2'b00, 2'b11, r0, r1, lat, rc, d, g, b);
      $display("txn directed1: ready=%b%b lat=%0d rst=%0d data=%h baud=%b", r0, r1, lat, rc, d, b);
      checks++; if (r1 !== 1'b1 || r0 !== 1'b0) begin errors++; $display("FAIL dir1_ready got %b%b want 01", r0, r1); end
      checks++; if (lat != SETTLE + 1 || rc != SETTLE) begin errors++; $display("FAIL dir1_latency got lat=%0d rst=%0d want lat=%0d rst=%0d", lat, rc, SETTLE + 1, SETTLE); end
      checks++; if (b !== 2'b11 || d !== 8'h3C || g !== 1'b1) begin errors++; $display("FAIL dir1_cfg got %b/%h/%b want 11/3c/1", b, d, g); end
      finish_txn(1);
      m_last = 1'b1;
      m_baud = 2'b11;
   endtask

   task automatic test_random();
      logic r0, r1, g; int lat, rc, w; logic [7:0] d, d0, d1, exp_d; logic [1:0] b, b0, b1, v, exp_b; logic reconf;
      for (int k = 0; k < 24; k++) begin
         v  = 2'($urandom_range(1, 3));
         d0 = 8'($urandom); d1 = 8'($urandom);
         b0 = 2'($urandom); b1 = 2'($urandom);
         w      = model_winner(v[0], v[1], m_last);
         exp_b  = (w == 1) ? b1 : b0;
         exp_d  = (w == 1) ? d1 : d0;
         reconf = (exp_b != m_baud);
         run_accept(v[0], v[1], d0, d1, b0, b1, r0, r1, lat, rc, d, g, b);
         $display("txn random%0d: v=%b ready=%b%b lat=%0d rst=%0d data=%h grant=%b baud=%b", k, v, r0, r1, lat, rc, d, g, b);
         checks++; if (r0 !== (w == 0) || r1 !== (w == 1)) begin errors++; $display("FAIL rnd_ready got %b%b want winner %0d", r0, r1, w); end
         checks++; if (lat != (reconf ? SETTLE + 1 : 1)) begin errors++; $display("FAIL rnd_latency got %0d want %0d", lat, reconf ? SETTLE + 1 : 1); end
         checks++; if (rc != (reconf ? SETTLE : 0)) begin errors++; $display("FAIL rnd_baud_rst got %0d want %0d", rc, reconf ? SETTLE : 0); end
         checks++; if (d !== exp_d || g !== w[0] || b !== exp_b) begin errors++; $display("FAIL rnd_payload got %h/%b/%b want %h/%b/%b", d, g, b, exp_d, w[0], exp_b); end
         finish_txn($urandom_range(1, 6));
         checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rnd_return got busy=%b err=%b want 0/0", bus.busy, bus.timeout_err); end
         m_last = w[0];
         m_baud = exp_b;
      end
   endtask

   task automatic test_back_to_back();
      int found; logic r0, r1;
      for (int k = 0; k < 4; k++) begin
         found = 0; r0 = 1'b0; r1 = 1'b0;
         for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            bus.tx_done = 1'b0;
            bus.req0_valid = 1'b1; bus.req0_data = 8'h10; bus.req0_baud = m_baud;
            bus.req1_valid = 1'b1; bus.req1_data = 8'h21; bus.req1_baud = m_baud;
            #1;
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            if (r0 || r1) begin found = 1; break; end
         end
         $display("txn b2b%0d: ready=%b%b", k, r0, r1);
         checks++; if (found == 0 || r0 !== (k % 2 == 0) || r1 !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_grant got %b%b want %0d", r0, r1, k % 2); end
         found = 0;
         for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (bus.tx_start) begin found = 1; break; end
         end
         checks++; if (found == 0 || bus.grant !== 1'(k % 2) || bus.tx_data !== ((k % 2 == 1) ? 8'h21 : 8'h10)) begin errors++; $display("FAIL b2b_start got start=%0d grant=%b data=%h want 1/%0d", found, bus.grant, bus.tx_data, k % 2); end
         repeat (3) @(negedge clock);
         bus.tx_done = 1'b1;
      end
      @(negedge clock);
      bus.tx_done = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      m_last = 1'b1;
   endtask

   task automatic test_timeout();
      logic r0, r1, g; int lat, rc, n_err; logic [7:0] d; logic [1:0] b;
      run_accept(1'b1, 1'b0, 8'h77, 8'h00, m_baud, 2'b00, r0, r1, lat, rc, d, g, b);
      n_err = -1;
      for (int i = 1; i <= TMO + 20; i++) begin
         @(negedge clock);
         if (bus.timeout_err) begin n_err = i; break; end
      end
      $display("txn timeout: lat=%0d err_after=%0d busy=%b", lat, n_err, bus.busy);
      checks++; if (n_err != TMO + 1) begin errors++; $display("FAIL tmo_cycles got %0d want %0d", n_err, TMO + 1); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", bus.busy); end
      @(negedge clock);
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse got %b want 0", bus.timeout_err); end
      m_last = 1'b0;
      run_accept(1'b1, 1'b1, 8'h01, 8'h88, m_baud, m_baud, r0, r1, lat, rc, d, g, b);
      $display("txn after_timeout: ready=%b%b lat=%0d data=%h", r0, r1, lat, d);
      checks++; if (r1 !== 1'b1 || r0 !== 1'b0 || lat != 1 || d !== 8'h88) begin errors++; $display("FAIL tmo_next got %b%b lat=%0d data=%h want 01 lat=1 data=88", r0, r1, lat, d); end
      repeat (TMO) @(negedge clock);
      bus.tx_done = 1'b1;
      @(negedge clock);
      bus.tx_done = 1'b0;
      $display("txn done_on_terminal: err=%b busy=%b", bus.timeout_err, bus.busy);
      checks++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_terminal_done got err=%b busy=%b want 0/0", bus.timeout_err, bus.busy); end
      m_last = 1'b1;
   endtask

   task automatic test_reset_mid_cfg();
      int seen;
      @(negedge clock);
      bus.req0_valid = 1'b1; bus.req0_data = 8'h5A;
      bus.req0_baud = (m_baud == 2'b01) ? 2'b00 : 2'b01;
      #1;
      checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", bus.req0_ready); end
      @(negedge clock);
      bus.req0_valid = 1'b0;
      checks++; if (bus.baud_rst !== 1'b1 || bus.baud_rate !== bus.req0_baud) begin errors++; $display("FAIL mid_cfg got rst=%b baud=%b want 1/%b", bus.baud_rst, bus.baud_rate, bus.req0_baud); end
      @(negedge clock);
      rst_n = 1'b0;
      @(negedge clock);
      checks++; if (bus.baud_rate !== 2'b10 || bus.baud_rst !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset got baud=%b rst=%b busy=%b want 10/1/0", bus.baud_rate, bus.baud_rst, bus.busy); end
      rst_n = 1'b1;
      @(negedge clock);
      checks++; if (bus.baud_rst !== 1'b0) begin errors++; $display("FAIL mid_release got %b want 0", bus.baud_rst); end
      seen = 0;
      repeat (12) begin
         @(negedge clock);
         if (bus.tx_start) seen = 1;
      end
      $display("txn reset_mid_cfg: tx_start_seen=%0d busy=%b", seen, bus.busy);
      checks++; if (seen != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_abandon got start=%0d busy=%b want 0/0", seen, bus.busy); end
      m_last = 1'b1;
      m_baud = 2'b10;
   endtask

   task automatic test_ignore_done();
      int lat;
      @(negedge clock);
      bus.tx_done = 1'b1;
      @(negedge clock);
      bus.tx_done = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0 || bus.tx_start !== 1'b0) begin errors++; $display("FAIL ign_idle got busy=%b err=%b start=%b want 000", bus.busy, bus.timeout_err, bus.tx_start); end
      @(negedge clock);
      bus.req1_valid = 1'b1; bus.req1_data = 8'hC3; bus.req1_baud = 2'b00;
      #1;
      checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL ign_ready got %b want 1", bus.req1_ready); end
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         bus.req1_valid = 1'b0;
         bus.tx_done = (n == 2);
         if (bus.tx_start) begin lat = n; break; end
      end
      $display("txn ignore_done_cfg: lat=%0d busy=%b", lat, bus.busy);
      checks++; if (lat != SETTLE + 1 || bus.busy !== 1'b1) begin errors++; $display("FAIL ign_cfg got lat=%0d busy=%b want %0d/1", lat, bus.busy, SETTLE + 1); end
      // A request raised and withdrawn while busy must not be accepted.
      @(negedge clock);
      bus.req0_valid = 1'b1; bus.req0_data = 8'hEE; bus.req0_baud = 2'b00;
      @(negedge clock);
      bus.req0_valid = 1'b0;
      finish_txn(1);
      repeat (2) @(negedge clock);
      $display("txn withdrawn: busy=%b data=%h", bus.busy, bus.tx_data);
      checks++; if (bus.busy !== 1'b0 || bus.tx_data !== 8'hC3) begin errors++; $display("FAIL ign_withdrawn got busy=%b data=%h want 0/c3", bus.busy, bus.tx_data); end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_directed();
      test_random();
      do_reset();
      test_back_to_back();
      test_timeout();
      test_reset_mid_cfg();
      test_ignore_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles baud_rst is held after a baud-rate change (valid range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 600000: maximum cycles spent in WAIT before tx_done is declared missing (20-bit counter).
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 has a byte pending; held with data until req0_ready.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_baud  input  2  requester 0 baud select (00=2400, 01=4800, 10=9600, 11=19.2K).
REQ-008 req0_ready  output  1  request accepted this cycle.
REQ-009 req1_valid, req1_data, req1_baud, req1_ready: same directions, widths and meaning as requester 0.
REQ-010 baud_rate  output  2  configuration to the shared baud generator.
REQ-011 baud_rst  output  1  active-high reset to the shared baud generator.
REQ-012 tx_start  output  1  one-cycle start pulse to the shared transmitter.
REQ-013 tx_data  output  8  byte to transmit.
REQ-014 tx_done  input  1  one-cycle pulse from the transmitter at end of frame.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant  output  1  index of the requester owning the transmitter (valid while busy).
REQ-017 timeout_err  output  1  one-cycle pulse on WAIT timeout.

Function
REQ-018 FSM states SHALL be IDLE, CFG, START, WAIT; all outputs except reqN_ready registered.
REQ-019 IDLE: with any valid, the block SHALL accept exactly one requester; one valid wins outright; both valid -> the requester not granted last wins (round-robin).
REQ-020 reqN_ready SHALL be combinational, high only in IDLE for the winner of that cycle; never both high.
REQ-021 On accept the block SHALL latch data, baud select and grant; tx_data holds the latched byte until the next accept.
REQ-022 Latched baud != current baud_rate -> next state CFG; equal -> next state START.
REQ-023 CFG: baud_rate SHALL update on CFG entry; baud_rst high for exactly SETTLE_CYCLES cycles, then START.
REQ-024 START: tx_start high for exactly one cycle, then WAIT.
REQ-025 Latency: accept at edge T -> tx_start high in cycle T+1 (no reconfig) or T+1+SETTLE_CYCLES (reconfig).
REQ-026 WAIT: tx_done -> IDLE and round-robin pointer records grant; the next accept can occur in the cycle after return.
REQ-027 WAIT timeout: counter cleared on WAIT entry; reaching TIMEOUT_CYCLES without tx_done -> timeout_err pulse, IDLE, pointer still updated.
REQ-028 tx_done coincident with timeout terminal count SHALL count as done; no timeout_err.
REQ-029 tx_done outside WAIT SHALL be ignored.
REQ-030 Valid deasserted before ready is not an error; no accept occurs.

Reset
REQ-031 rst_n low at an edge SHALL force IDLE: baud_rate=2'b10, baud_rst=1, tx_start=0, tx_data=0, busy=0, grant=0, timeout_err=0, timeout counter=0, pointer=1 (requester 0 wins first tie).
REQ-032 baud_rst SHALL clear at the first edge with rst_n high.
REQ-033 Reset mid-CFG/START/WAIT SHALL abandon the transfer with no tx_start issued afterward.

Verification
REQ-034 After reset, req0 valid, data 8'hA5, baud 2'b10 -> req0_ready in that cycle, no CFG, tx_start one cycle later with tx_data=8'hA5.
REQ-035 req1 valid, baud 2'b11 -> baud_rate=2'b11, baud_rst high 4 cycles, tx_start in cycle T+5.
REQ-036 Both valid continuously, tx_done returned 3 cycles after each tx_start -> grants alternate 0,1,0,1, first grant 0.
REQ-037 No tx_done after tx_start -> timeout_err single pulse after 600000 WAIT cycles, busy falls, next request accepted.
REQ-038 rst_n low for one cycle during CFG -> baud_rate=2'b10, baud_rst high then low next cycle, no tx_start, state IDLE.
REQ-039 tx_done in IDLE and CFG -> ignored; tx_done on timeout terminal cycle -> no timeout_err.
